// File: rtl/branch_unit_if.sv
// Pipeline-side bundle for branch_unit: accumulator writeback, branch request, and branch/flush outputs.
// Statistics signals exist only when BRANCH_STATS_EN is defined.
interface branch_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 16
);
    logic [DATA_W-1:0] Acc;
    logic              AccWrite;
    logic              BranchCycle;
    logic [2:0]        BranchCond;
    logic [PC_W-1:0]   BranchTarget;
    logic              DoBranch;
    logic [PC_W-1:0]   TargetPC;
    logic              Flush;
    logic              Busy;
`ifdef BRANCH_STATS_EN
    logic              StatsClr;
    logic [15:0]       BranchCount;
    logic [15:0]       TakenCount;

    modport master (
        output Acc, AccWrite, BranchCycle, BranchCond, BranchTarget, StatsClr,
        input  DoBranch, TargetPC, Flush, Busy, BranchCount, TakenCount
    );
    modport slave (
        input  Acc, AccWrite, BranchCycle, BranchCond, BranchTarget, StatsClr,
        output DoBranch, TargetPC, Flush, Busy, BranchCount, TakenCount
    );
`else
    modport master (
        output Acc, AccWrite, BranchCycle, BranchCond, BranchTarget,
        input  DoBranch, TargetPC, Flush, Busy
    );
    modport slave (
        input  Acc, AccWrite, BranchCycle, BranchCond, BranchTarget,
        output DoBranch, TargetPC, Flush, Busy
    );
`endif
endinterface

// File: rtl/branch_unit.sv
// Registered branch resolution with N/Z flags and a post-branch flush window.
// Optional BRANCH_STATS_EN adds saturating evaluated/taken branch counters.
module branch_unit #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned PC_W         = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    branch_unit_if.slave bus
);
    typedef enum logic {IDLE, FLUSH} state_e;

    state_e          state_q;
    logic            flag_n_q, flag_z_q;
    logic            do_branch_q, flush_q;
    logic [PC_W-1:0] target_q;
    logic [3:0]      cnt_q;

    logic eval_n, eval_z, cond_true, taken_d, bypass;

    always_comb begin
        // Same-cycle accumulator write is forwarded so the branch sees the new value.
        bypass    = bus.AccWrite && bus.BranchCycle;
        eval_n    = bypass ? bus.Acc[DATA_W-1] : flag_n_q;
        eval_z    = bypass ? (bus.Acc == '0) : flag_z_q;
        cond_true = 1'b0;
        case (bus.BranchCond)
            3'b000:  cond_true = eval_n;
            3'b001:  cond_true = eval_z;
            3'b010:  cond_true = !eval_z;
            3'b011:  cond_true = !eval_n && !eval_z;
            3'b100:  cond_true = 1'b1;
            3'b101:  cond_true = !eval_n;
            3'b110:  cond_true = eval_n || eval_z;
            default: cond_true = 1'b0;
        endcase
        taken_d = bus.BranchCycle && (state_q == IDLE) && cond_true;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b1;
            do_branch_q <= 1'b0;
            flush_q     <= 1'b0;
            target_q    <= '0;
            cnt_q       <= '0;
        end else begin
            if (bus.AccWrite) begin
                flag_n_q <= bus.Acc[DATA_W-1];
                flag_z_q <= (bus.Acc == '0);
            end
            do_branch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (taken_d) begin
                        do_branch_q <= 1'b1;
                        target_q    <= bus.BranchTarget;
                        if (FLUSH_CYCLES != 0) begin
                            state_q <= FLUSH;
                            cnt_q   <= 4'(FLUSH_CYCLES);
                            flush_q <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.DoBranch = do_branch_q;
    assign bus.TargetPC = target_q;
    assign bus.Flush    = flush_q;
    assign bus.Busy     = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_cnt_q, taken_cnt_q;
    logic        evaluated;

    assign evaluated = bus.BranchCycle && (state_q == IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (bus.StatsClr) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            if (evaluated && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 16'd1;
            if (taken_d && (taken_cnt_q != '1))    taken_cnt_q  <= taken_cnt_q + 16'd1;
        end
    end

    assign bus.BranchCount = branch_cnt_q;
    assign bus.TakenCount  = taken_cnt_q;
`endif
endmodule

// File: tb/tb_branch_unit.sv
// Directed scoreboard bench: one branch_unit with a 2-cycle flush window and one with none.
module tb_branch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          sel;
        logic        e_do;
        logic [15:0] e_tpc;
        logic        e_fl;
        logic        e_busy;
        string       tag;
    } exp_t;
    exp_t sb[$];

    branch_unit_if #(.DATA_W(16), .PC_W(16)) b2 ();
    branch_unit_if #(.DATA_W(16), .PC_W(16)) b0 ();

    branch_unit #(.DATA_W(16), .PC_W(16), .FLUSH_CYCLES(2)) dut2 (
        .Clk(clk), .Rst_n(rst_n), .bus(b2.slave));
    branch_unit #(.DATA_W(16), .PC_W(16), .FLUSH_CYCLES(0)) dut0 (
        .Clk(clk), .Rst_n(rst_n), .bus(b0.slave));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 16'd1, 16'd0);
            return;
        end
        e = sb.pop_front();
        if (e.sel) begin
            chk({e.tag, ".DoBranch"}, {15'd0, b0.DoBranch}, {15'd0, e.e_do});
            chk({e.tag, ".TargetPC"}, b0.TargetPC, e.e_tpc);
            chk({e.tag, ".Flush"},    {15'd0, b0.Flush}, {15'd0, e.e_fl});
            chk({e.tag, ".Busy"},     {15'd0, b0.Busy},  {15'd0, e.e_busy});
        end else begin
            chk({e.tag, ".DoBranch"}, {15'd0, b2.DoBranch}, {15'd0, e.e_do});
            chk({e.tag, ".TargetPC"}, b2.TargetPC, e.e_tpc);
            chk({e.tag, ".Flush"},    {15'd0, b2.Flush}, {15'd0, e.e_fl});
            chk({e.tag, ".Busy"},     {15'd0, b2.Busy},  {15'd0, e.e_busy});
        end
    endtask

    // sel=0 drives the FLUSH_CYCLES=2 unit, sel=1 the FLUSH_CYCLES=0 unit; the other idles.
    task automatic step(input bit sel, input logic aw, input logic [15:0] acc,
                        input logic bc, input logic [2:0] cond, input logic [15:0] tgt,
                        input logic e_do, input logic [15:0] e_tpc,
                        input logic e_fl, input logic e_busy, input string tag);
        b2.AccWrite = 1'b0; b2.BranchCycle = 1'b0; b2.BranchCond = 3'bxxx;
        b0.AccWrite = 1'b0; b0.BranchCycle = 1'b0; b0.BranchCond = 3'bxxx;
        if (sel) begin
            b0.AccWrite = aw; b0.Acc = acc; b0.BranchCycle = bc;
            b0.BranchCond = cond; b0.BranchTarget = tgt;
        end else begin
            b2.AccWrite = aw; b2.Acc = acc; b2.BranchCycle = bc;
            b2.BranchCond = cond; b2.BranchTarget = tgt;
        end
        sb.push_back('{sel, e_do, e_tpc, e_fl, e_busy, tag});
        @(posedge clk);
        #1;
        compare_next();
    endtask

    initial begin
        b2.Acc = '0; b2.AccWrite = 1'b0; b2.BranchCycle = 1'b0; b2.BranchCond = '0; b2.BranchTarget = '0;
        b0.Acc = '0; b0.AccWrite = 1'b0; b0.BranchCycle = 1'b0; b0.BranchCond = '0; b0.BranchTarget = '0;
`ifdef BRANCH_STATS_EN
        b2.StatsClr = 1'b0;
        b0.StatsClr = 1'b0;
`endif
        #2;
        chk("reset.DoBranch", {15'd0, b2.DoBranch}, 16'd0);
        chk("reset.TargetPC", b2.TargetPC, 16'h0000);
        chk("reset.Flush",    {15'd0, b2.Flush}, 16'd0);
        chk("reset.Busy",     {15'd0, b2.Busy},  16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Negative flag then bin, with a two-cycle flush window.
        step(0, 1, 16'h8000, 0, 3'bxxx, 16'h0000, 0, 16'h0000, 0, 0, "wr_neg");
        step(0, 0, 16'h0000, 1, 3'b000, 16'h0040, 1, 16'h0040, 1, 1, "bin_taken");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0040, 1, 1, "flush1");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0040, 0, 0, "flush_end");
        // Zero flag: binz not taken, bifz taken.
        step(0, 1, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0040, 0, 0, "wr_zero");
        step(0, 0, 16'h0000, 1, 3'b010, 16'h0080, 0, 16'h0040, 0, 0, "binz_nt");
        step(0, 0, 16'h0000, 1, 3'b001, 16'h0080, 1, 16'h0080, 1, 1, "bifz_taken");
        // Branch during flush ignored; flags still update.
        step(0, 1, 16'h0005, 1, 3'b100, 16'h00C0, 0, 16'h0080, 1, 1, "b_in_flush");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0080, 0, 0, "flush_end2");
        step(0, 0, 16'h0000, 1, 3'b011, 16'h00C0, 1, 16'h00C0, 1, 1, "bip_after_flush");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h00C0, 1, 1, "flush1b");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h00C0, 0, 0, "flush_end3");
        // Registered Z=1 but same-cycle write of 5 makes bip taken.
        step(0, 1, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h00C0, 0, 0, "wr_zero2");
        step(0, 1, 16'h0005, 1, 3'b011, 16'h0100, 1, 16'h0100, 1, 1, "bypass_bip");

        // Asynchronous reset in the middle of the flush window.
        rst_n = 1'b0;
        #1;
        chk("midrst.Flush",    {15'd0, b2.Flush}, 16'd0);
        chk("midrst.Busy",     {15'd0, b2.Busy},  16'd0);
        chk("midrst.TargetPC", b2.TargetPC, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Flags reset to N=0 Z=1.
        step(0, 0, 16'h0000, 1, 3'b001, 16'h0200, 1, 16'h0200, 1, 1, "rst_flagz");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0200, 1, 1, "flush1c");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0200, 0, 0, "flush_end4");
        step(0, 0, 16'h0000, 1, 3'b111, 16'h0300, 0, 16'h0200, 0, 0, "nop_nt");
        step(0, 0, 16'h0000, 1, 3'b000, 16'h0300, 0, 16'h0200, 0, 0, "bin_nt");
        step(0, 0, 16'h0000, 1, 3'b110, 16'h0300, 1, 16'h0300, 1, 1, "binp_taken");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0300, 1, 1, "flush1d");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0300, 0, 0, "flush_end5");

        // No flush window: back-to-back taken branches.
        step(1, 0, 16'h0000, 1, 3'b100, 16'h0010, 1, 16'h0010, 0, 0, "nf_b1");
        step(1, 0, 16'h0000, 1, 3'b100, 16'h0020, 1, 16'h0020, 0, 0, "nf_b2");
        step(1, 0, 16'h0000, 1, 3'b101, 16'h0030, 1, 16'h0030, 0, 0, "nf_binn");
        step(1, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0030, 0, 0, "nf_idle");
        step(1, 0, 16'h0000, 1, 3'b010, 16'h0040, 0, 16'h0030, 0, 0, "nf_binz_nt");

`ifdef BRANCH_STATS_EN
        // Clear has priority over the simultaneous evaluated branch.
        b2.StatsClr = 1'b1;
        step(0, 0, 16'h0000, 1, 3'b111, 16'h0000, 0, 16'h0300, 0, 0, "st_clr");
        b2.StatsClr = 1'b0;
        chk("st_clr.BranchCount", b2.BranchCount, 16'd0);
        chk("st_clr.TakenCount",  b2.TakenCount,  16'd0);
        step(0, 0, 16'h0000, 1, 3'b111, 16'h0400, 0, 16'h0300, 0, 0, "st_nop");
        step(0, 0, 16'h0000, 1, 3'b100, 16'h0400, 1, 16'h0400, 1, 1, "st_b1");
        step(0, 0, 16'h0000, 1, 3'b100, 16'h0480, 0, 16'h0400, 1, 1, "st_ignored");
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0400, 0, 0, "st_fe");
        step(0, 0, 16'h0000, 1, 3'b100, 16'h0500, 1, 16'h0500, 1, 1, "st_b2");
        chk("st.BranchCount", b2.BranchCount, 16'd3);
        chk("st.TakenCount",  b2.TakenCount,  16'd2);
        b2.StatsClr = 1'b1;
        step(0, 0, 16'h0000, 0, 3'bxxx, 16'h0000, 0, 16'h0500, 1, 1, "st_clr2");
        b2.StatsClr = 1'b0;
        chk("st_clr2.BranchCount", b2.BranchCount, 16'd0);
        chk("st_clr2.TakenCount",  b2.TakenCount,  16'd0);

        // Saturation: 65537 taken branches on the no-flush unit.
        b0.StatsClr = 1'b1;
        @(posedge clk); #1;
        b0.StatsClr = 1'b0;
        b0.BranchCycle = 1'b1;
        b0.BranchCond = 3'b100;
        for (int i = 0; i < 65537; i++) begin
            @(posedge clk);
        end
        #1;
        b0.BranchCycle = 1'b0;
        chk("sat.BranchCount", b0.BranchCount, 16'hFFFF);
        chk("sat.TakenCount",  b0.TakenCount,  16'hFFFF);
`endif

        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Parametrised branch resolution unit for the MISP core, replacing the combinational branch logic unit.
- Maintains registered N/Z flags from accumulator writes.
- Evaluates eight 3-bit branch conditions and registers the taken decision and target PC.
- Drives a pipeline-flush window of configurable length after each taken branch.
- Sits between the accumulator writeback path and the PC/fetch stage.

Parameters:
DATA_W, 16, accumulator width in bits (>=2)
PC_W, 16, program counter / target width in bits
FLUSH_CYCLES, 2, cycles Flush stays high after a taken branch (0..15; 0 = no flush window)

Ports:
Clk  input  1  system clock, all state on rising edge
Rst_n  input  1  asynchronous active-low reset
Acc  input  DATA_W  accumulator value
AccWrite  input  1  Acc is being written this cycle; flags capture Acc
BranchCycle  input  1  current instruction is a branch; evaluate this cycle
BranchCond  input  3  condition code, see Behaviour
BranchTarget  input  PC_W  target address of the branch instruction
DoBranch  output  1  registered taken pulse, 1 cycle wide
TargetPC  output  PC_W  registered target, valid while DoBranch=1, holds value otherwise
Flush  output  1  high while fetch/decode contents must be discarded
Busy  output  1  high in FLUSH state; BranchCycle ignored

Behaviour:
- Reset (Rst_n=0, async): DoBranch=0, TargetPC=0, Flush=0, Busy=0, FlagN=0, FlagZ=1, state=IDLE. Reset mid-flush aborts the window immediately.
- Flags: on AccWrite, FlagN<=Acc[DATA_W-1] and FlagZ<=(Acc==0).
- Evaluation flags: if AccWrite and BranchCycle are high in the same cycle, evaluation uses live Acc (bypass). Otherwise it uses registered flags.
- Conditions (N, Z = evaluation flags):
  - 000 bin: N
  - 001 bifz: Z
  - 010 binz: !Z
  - 011 bip: !N & !Z
  - 100 b: always
  - 101 binn: !N
  - 110 binp: N | Z
  - 111 nop: never
- States IDLE and FLUSH.
- IDLE with BranchCycle=1 and condition true:
  - Next edge: DoBranch=1 for exactly one cycle; TargetPC<=BranchTarget.
  - If FLUSH_CYCLES>0: go to FLUSH, counter<=FLUSH_CYCLES, Flush=1 and Busy=1 from the same edge.
  - If FLUSH_CYCLES=0: stay IDLE; Flush and Busy never assert.
- IDLE with BranchCycle=1 and condition false: DoBranch=0; no other state change.
- IDLE with BranchCycle=0: DoBranch=0.
- FLUSH:
  - Counter decrements each cycle.
  - Flush stays high for exactly FLUSH_CYCLES cycles, then returns to IDLE with Flush=0 and Busy=0.
  - BranchCycle is ignored (flushed instruction): no evaluation, no DoBranch.
  - AccWrite still updates flags.
- Latency: decision registered 1 cycle after BranchCycle. Back-to-back branches in consecutive IDLE cycles with FLUSH_CYCLES=0 each produce their own DoBranch pulse.
- X-safety: BranchCond is ignored when BranchCycle=0.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: adds outputs BranchCount[15:0] and TakenCount[15:0], plus input StatsClr (synchronous clear, priority over increment).
  - BranchCount increments on each evaluated BranchCycle (IDLE only).
  - TakenCount increments on each taken branch.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then AccWrite Acc=16'h8000, next cycle BranchCycle cond=000 target=16'h0040 -> next edge DoBranch=1, TargetPC=16'h0040, Flush high 2 cycles, Busy high 2 cycles.
- Flags Z=1 (Acc=0 written), cond=010 -> DoBranch stays 0, Flush stays 0. Repeat with cond=001 -> taken.
- Same-cycle AccWrite Acc=16'h0005 with BranchCycle cond=011 while registered Z=1 -> taken (bypass), DoBranch=1.
- Taken branch, then BranchCycle cond=100 during FLUSH -> no second DoBranch, TargetPC unchanged. Branch one cycle after Flush drops -> taken.
- FLUSH_CYCLES=0 build, taken branches on two consecutive cycles -> two DoBranch pulses, Flush/Busy never high. Assert Rst_n low mid-flush in default build -> Flush=0, Busy=0 immediately.
- BRANCH_STATS_EN: 3 evaluated branches, 2 taken -> BranchCount=3, TakenCount=2. StatsClr -> both 0. Preload near 16'hFFFF -> counters saturate at 16'hFFFF.
